// File: rtl/calc_pkg.sv
// calc_pkg: shared state encodings, display codes and data width for the calculator control
package calc_pkg;
  localparam int DATA_W = 4;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    GET_OP = 3'd3,
    EXEC   = 3'd4,
    SHOW   = 3'd5,
    ERR    = 3'd6
  } state_t;
  localparam logic [1:0] DISP_A   = 2'b00;
  localparam logic [1:0] DISP_B   = 2'b01;
  localparam logic [1:0] DISP_RES = 2'b10;
  localparam logic [1:0] DISP_ERR = 2'b11;
endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: panel/ALU inputs and register strobes, display and debug outputs of the sequencer
//   master: panel/datapath side (drives enter, cancel, div_by_zero)
//   slave:  sequencer side (drives strobes, disp_sel, busy, error, state_o)
interface calc_sequencer_if;
  logic       enter;
  logic       cancel;
  logic       div_by_zero;
  logic       a_load;
  logic       b_load;
  logic       op_load;
  logic       res_load;
  logic       reg_clear;
  logic [1:0] disp_sel;
  logic       busy;
  logic       error;
  logic [2:0] state_o;
  modport master (
    output enter, cancel, div_by_zero,
    input  a_load, b_load, op_load, res_load, reg_clear, disp_sel, busy, error, state_o
  );
  modport slave (
    input  enter, cancel, div_by_zero,
    output a_load, b_load, op_load, res_load, reg_clear, disp_sel, busy, error, state_o
  );
endinterface

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer plus rising-edge detector for a raw pushbutton level
//   clk, clear_n (async active-low), btn_in (asynchronous level), edge_out (one-cycle pulse per rise)
module btn_sync_edge (
  input  logic clk,
  input  logic clear_n,
  input  logic btn_in,
  output logic edge_out
);
  logic s1, s2, prev;
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= btn_in;
      s2   <= s1;
      prev <= s2;
    end
  assign edge_out = s2 & ~prev;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM stepping operand A, operand B and opcode entry, ALU settle and result capture
//   clk, clear_n (async active-low), bus (calc_sequencer_if.slave: panel inputs, strobes, display, debug)
//   EXEC_CYCLES: ALU settle cycles spent in EXEC (1..15)
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input logic             clk,
  input logic             clear_n,
  calc_sequencer_if.slave bus
);
  localparam logic [DATA_W-1:0] CNT_INIT = DATA_W'(EXEC_CYCLES);
  state_t            state, nxt;
  logic [DATA_W-1:0] cnt;
  logic              enter_edge;
  logic              a_nx, b_nx, op_nx, res_nx, clr_nx;
  logic [1:0]        disp_nx;
  btn_sync_edge u_enter (
    .clk      (clk),
    .clear_n  (clear_n),
    .btn_in   (bus.enter),
    .edge_out (enter_edge)
  );
  // Outputs are registered from next-cycle values so they change together with state.
  // The counter reloads outside EXEC, so entering EXEC always starts at EXEC_CYCLES.
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.a_load    <= 1'b0;
      bus.b_load    <= 1'b0;
      bus.op_load   <= 1'b0;
      bus.res_load  <= 1'b0;
      bus.reg_clear <= 1'b0;
      bus.disp_sel  <= DISP_A;
      bus.busy      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      state         <= nxt;
      cnt           <= (state == EXEC) ? cnt - 1'b1 : CNT_INIT;
      bus.a_load    <= a_nx;
      bus.b_load    <= b_nx;
      bus.op_load   <= op_nx;
      bus.res_load  <= res_nx;
      bus.reg_clear <= clr_nx;
      bus.disp_sel  <= disp_nx;
      bus.busy      <= nxt == EXEC;
      bus.error     <= nxt == ERR;
    end
  // cancel overrides everything except IDLE, which always falls through to GET_A.
  // Edges arriving in IDLE or EXEC are simply not looked at, so they are dropped.
  always_comb begin
    nxt = IDLE;
    if (state != IDLE && bus.cancel) nxt = IDLE;
    else
      case (state)
        IDLE:      nxt = GET_A;
        GET_A:     nxt = enter_edge ? GET_B : GET_A;
        GET_B:     nxt = enter_edge ? GET_OP : GET_B;
        GET_OP:    nxt = enter_edge ? EXEC : GET_OP;
        EXEC:      nxt = (cnt > 4'd1) ? EXEC : (bus.div_by_zero ? ERR : SHOW);
        SHOW, ERR: nxt = enter_edge ? IDLE : state;
        default:   nxt = IDLE;
      endcase
  end
  // Strobes are tied to specific transitions, which keeps them mutually exclusive.
  always_comb begin
    clr_nx  = state == IDLE;
    a_nx    = state == GET_A && nxt == GET_B;
    b_nx    = state == GET_B && nxt == GET_OP;
    op_nx   = state == GET_OP && nxt == EXEC;
    res_nx  = state == EXEC && nxt == SHOW;
    disp_nx = (nxt == SHOW) ? DISP_RES :
              (nxt == ERR) ? DISP_ERR :
              (nxt == GET_B || nxt == GET_OP || nxt == EXEC) ? DISP_B : DISP_A;
  end
  assign bus.state_o = state;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench with a strobe scoreboard for calc_sequencer
module tb_calc_sequencer;
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #10 clk = ~clk;
  calc_sequencer_if b2 ();
  calc_sequencer_if b3 ();
  calc_sequencer #(.EXEC_CYCLES(2)) u2 (.clk(clk), .clear_n(clear_n), .bus(b2));
  calc_sequencer #(.EXEC_CYCLES(3)) u3 (.clk(clk), .clear_n(clear_n), .bus(b3));
  assign b3.enter       = b2.enter;
  assign b3.cancel      = b2.cancel;
  assign b3.div_by_zero = b2.div_by_zero;
  int checks = 0;
  int errors = 0;
  int sb[$];
  int busy_cnt = 0;
  int a_cnt = 0;
  int res3_cnt = 0;
  logic [3:0] sw = 4'b0101;
  logic [3:0] a_reg;
  logic [4:0] s2;
  assign s2 = {b2.reg_clear, b2.res_load, b2.op_load, b2.b_load, b2.a_load};
  always @(posedge clk or negedge clear_n)
    if (!clear_n) a_reg <= '0;
    else if (b2.reg_clear) a_reg <= '0;
    else if (b2.a_load) a_reg <= sw;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int strobe_code(logic [4:0] s);
    for (int i = 4; i >= 0; i--) if (s[i]) return i + 1;
    return 0;
  endfunction
  // strobe codes: 1=a_load 2=b_load 3=op_load 4=res_load 5=reg_clear
  always @(posedge clk) begin
    #2;
    if (b2.busy) busy_cnt++;
    if (b2.a_load) a_cnt++;
    if (b3.res_load) res3_cnt++;
    if (s2 != 5'd0) begin
      chk("strobe_onehot", $countones(s2), 1);
      if (sb.size() == 0) chk("unexpected_strobe", strobe_code(s2), 0);
      else chk("strobe_order", strobe_code(s2), sb.pop_front());
    end
  end
  // Enter rises at a negedge and is held two cycles; returns at the negedge after the 2nd posedge.
  task automatic press();
    b2.enter = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b2.enter = 1'b0;
  endtask
  task automatic strobe_timing(string tag, int code);
    chk({tag, "_pre"}, strobe_code(s2), 0);
    @(negedge clk);
    chk({tag, "_on"}, strobe_code(s2), code);
    @(negedge clk);
    chk({tag, "_off"}, strobe_code(s2), 0);
  endtask
  task automatic wait_state(string tag, int s, int budget);
    int n = 0;
    while (b2.state_o != 3'(s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, b2.state_o, s);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    int b0, a0, r0;
    b2.enter = 1'b0;
    b2.cancel = 1'b0;
    b2.div_by_zero = 1'b0;
    #25;
    sb.push_back(5);
    clear_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("boot_state", b2.state_o, 1);
    #5 clear_n = 1'b0;
    #1;
    chk("rst_state", b2.state_o, 0);
    chk("rst_outs", {b2.a_load, b2.b_load, b2.op_load, b2.res_load, b2.reg_clear, b2.disp_sel, b2.busy, b2.error}, 0);
    #99;
    chk("rst_hold_state", b2.state_o, 0);
    sb.push_back(5);
    clear_n = 1'b1;
    #1;
    chk("rel_state", b2.state_o, 0);
    @(negedge clk);
    chk("rel_clr_on", b2.reg_clear, 1);
    chk("rel_state1", b2.state_o, 1);
    @(negedge clk);
    chk("rel_clr_off", b2.reg_clear, 0);
    sb.push_back(1);
    press();
    strobe_timing("a_load", 1);
    @(negedge clk);
    chk("a_reg", a_reg, 4'b0101);
    chk("state_getb", b2.state_o, 2);
    chk("disp_getb", b2.disp_sel, 2'b01);
    sb.push_back(2);
    press();
    strobe_timing("b_load", 2);
    @(negedge clk);
    chk("state_getop", b2.state_o, 3);
    b0 = busy_cnt;
    sb.push_back(3);
    sb.push_back(4);
    press();
    strobe_timing("op_load", 3);
    chk("exec_state", b2.state_o, 4);
    chk("exec_busy", b2.busy, 1);
    @(negedge clk);
    chk("res_load", b2.res_load, 1);
    chk("show_state", b2.state_o, 5);
    chk("show_disp", b2.disp_sel, 2'b10);
    chk("show_busy", b2.busy, 0);
    chk("busy_cycles", busy_cnt - b0, 2);
    sb.push_back(5);
    press();
    @(negedge clk);
    chk("show_to_idle", b2.state_o, 0);
    @(negedge clk);
    chk("show_clr", b2.reg_clear, 1);
    chk("show_geta", b2.state_o, 1);
    sb.push_back(1);
    a0 = a_cnt;
    b2.enter = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_state", b2.state_o, 2);
    chk("hold_one_aload", a_cnt - a0, 1);
    b2.enter = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_persist", b2.state_o, 2);
    sb.push_back(2);
    press();
    repeat (3) @(negedge clk);
    chk("hold_next", b2.state_o, 3);
    b2.div_by_zero = 1'b1;
    sb.push_back(3);
    press();
    wait_state("err_state", 6, 10);
    chk("err_flag", b2.error, 1);
    chk("err_disp", b2.disp_sel, 2'b11);
    chk("err_busy", b2.busy, 0);
    repeat (2) @(negedge clk);
    b2.div_by_zero = 1'b0;
    chk("err_state_u3", b3.state_o, 6);
    sb.push_back(5);
    press();
    @(negedge clk);
    chk("err_to_idle", b2.state_o, 0);
    @(negedge clk);
    chk("err_clr", b2.reg_clear, 1);
    chk("err_geta", b2.state_o, 1);
    sb.push_back(1);
    press();
    repeat (3) @(negedge clk);
    sb.push_back(2);
    press();
    repeat (3) @(negedge clk);
    chk("cancel_pre", b2.state_o, 3);
    sb.push_back(5);
    press();
    b2.cancel = 1'b1;
    @(negedge clk);
    b2.cancel = 1'b0;
    chk("cancel_no_op", b2.op_load, 0);
    chk("cancel_idle", b2.state_o, 0);
    @(negedge clk);
    chk("cancel_clr", b2.reg_clear, 1);
    chk("cancel_geta", b2.state_o, 1);
    sb.push_back(1);
    press();
    repeat (3) @(negedge clk);
    sb.push_back(2);
    press();
    repeat (3) @(negedge clk);
    r0 = res3_cnt;
    sb.push_back(3);
    press();
    @(negedge clk);
    chk("u3_exec_busy", b3.busy, 1);
    chk("u3_exec_state", b3.state_o, 4);
    #5 clear_n = 1'b0;
    #1;
    chk("u3_rst_busy", b3.busy, 0);
    chk("u3_rst_state", b3.state_o, 0);
    #99;
    sb.push_back(5);
    clear_n = 1'b1;
    #1;
    chk("u3_rel_state", b3.state_o, 0);
    @(negedge clk);
    chk("u3_rel_clr", b3.reg_clear, 1);
    chk("u3_rel_geta", b3.state_o, 1);
    repeat (4) @(negedge clk);
    chk("u3_no_res", res3_cnt - r0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control FSM for the calculator datapath. It steps the user through operand A, operand B and opcode entry by issuing single-cycle load strobes to the three 4-bit input registers. It then waits for the ALU to settle, captures the result, and selects what the display shows. It sits between the pushbutton/switch panel and the input, opcode and result registers.

Parameters:
EXEC_CYCLES, 1, ALU settle cycles spent in EXEC before result capture (legal range 1..15)

Ports:
clk  input  1  system clock, rising-edge
clear_n  input  1  asynchronous active-low reset
enter  input  1  raw pushbutton level, asynchronous to clk
cancel  input  1  synchronous abort request, already synchronous to clk
div_by_zero  input  1  ALU flag, valid during EXEC
a_load  output  1  load strobe to operand-A register
b_load  output  1  load strobe to operand-B register
op_load  output  1  load strobe to opcode register
res_load  output  1  load strobe to result register
reg_clear  output  1  clear strobe to all data registers
disp_sel  output  2  display source: 00=A, 01=B, 10=result, 11=error code
busy  output  1  high while in EXEC
error  output  1  high while in ERR
state_o  output  3  current state encoding, for debug

Behaviour:
- Reset (clear_n=0): takes effect immediately, with no clock edge required.
  - State goes to IDLE.
  - All strobes, busy and error go to 0; disp_sel=00.
  - Synchronizer flops and edge register go to 0.
- All outputs are registered. No combinational path runs from an input to an output.
- enter path: 2-flop synchronizer, then rising-edge detect (sync2 & ~prev).
  - An enter rise sampled at edge k produces a detected edge that the FSM acts on at edge k+2. The resulting strobe is high for exactly one cycle after edge k+2.
  - Holding enter high produces one edge only.
- States and encoding: IDLE=0, GET_A=1, GET_B=2, GET_OP=3, EXEC=4, SHOW=5, ERR=6. Code 7 is unused and recovers to IDLE.
- IDLE: reg_clear=1 for one cycle, then unconditionally to GET_A.
- GET_A (disp_sel=00): on edge, a_load=1 and go to GET_B.
- GET_B (disp_sel=01): on edge, b_load=1 and go to GET_OP.
- GET_OP (disp_sel=01): on edge, op_load=1, load the settle counter with EXEC_CYCLES, go to EXEC.
- EXEC (busy=1): the 4-bit counter decrements each cycle. When it reaches 0:
  - if div_by_zero=1, go to ERR with no res_load;
  - otherwise res_load=1 and go to SHOW.
  - Dwell in EXEC is exactly EXEC_CYCLES cycles.
- SHOW (disp_sel=10): on edge, go to IDLE.
- ERR (disp_sel=11, error=1): on edge, go to IDLE.
- cancel=1 in any state other than IDLE: next state is IDLE and no load strobe fires that cycle. cancel beats a simultaneous enter edge.
- Edges detected while in EXEC or IDLE are discarded, not queued.
- div_by_zero is only sampled in the final EXEC cycle and ignored elsewhere.
- Strobes are mutually exclusive. At most one of a_load, b_load, op_load, res_load, reg_clear is high in any cycle.
- A reset asserted mid-EXEC abandons the calculation. After release the next state is IDLE, so reg_clear fires one cycle later.

Decomposition:
- Shared package calc_pkg holds:
  - state encodings (IDLE..ERR);
  - DISP_A/DISP_B/DISP_RES/DISP_ERR codes;
  - data width constant 4.
- One sub-module: btn_sync_edge. It contains the 2-flop synchronizer plus rising-edge detector, with ports clk, clear_n, btn_in, edge_out. It is reusable for the cancel button later.

Test Plan:
Clock period is 20 ns throughout.
- Reset: clear_n=0 for 100 ns mid-clock -> all outputs 0, state_o=0 without a clock edge; release -> reg_clear high exactly one cycle, then state_o=1.
- Full calculation, EXEC_CYCLES=2: three enter pulses 100 ns apart ->
  - a_load, b_load, op_load each high one cycle, starting at the 3rd rising edge after each enter rise;
  - busy high 2 cycles, then res_load one cycle, state_o=5, disp_sel=10;
  - an inputRegister instance driven by a_load holds D=4'b0101.
- Enter held high 200 ns in GET_A -> exactly one a_load pulse; state GET_B persists until enter is released and pressed again.
- div_by_zero=1 through EXEC -> no res_load, state_o=6, error=1, disp_sel=11, busy=0; next enter -> IDLE, reg_clear pulse, state_o=1.
- In GET_OP, cancel=1 in the same cycle the enter edge is detected -> op_load stays 0, next state IDLE, reg_clear pulse one cycle later.
- clear_n pulled low during the 1st of 3 EXEC cycles (EXEC_CYCLES=3) -> busy=0 and state_o=0 immediately; res_load never asserts.
